// File: rtl/lpm_add_sub_pipe.sv
// Multi-lane adder/subtractor with carry-out, overflow and optional saturation,
// followed by a valid/ready pipeline of PIPELINE stages where bubbles collapse.
module lpm_add_sub_pipe #(
  parameter int LANE_WIDTH = 32,
  parameter int LANES      = 1,
  parameter int PIPELINE   = 2,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic                        clock,
  input  logic                        aclr_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*LANE_WIDTH-1:0] dataa,
  input  logic [LANES*LANE_WIDTH-1:0] datab,
  input  logic [LANES-1:0]            cin,
  input  logic                        add_sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*LANE_WIDTH-1:0] result,
  output logic [LANES-1:0]            cout,
  output logic [LANES-1:0]            overflow
);
  localparam int W = LANES * LANE_WIDTH;
  localparam logic [LANE_WIDTH-1:0] MAX_POS  = {1'b0, {(LANE_WIDTH-1){1'b1}}};
  localparam logic [LANE_WIDTH-1:0] MIN_NEG  = {1'b1, {(LANE_WIDTH-1){1'b0}}};
  localparam logic [LANE_WIDTH-1:0] ALL_ONES = {LANE_WIDTH{1'b1}};
  localparam logic [LANE_WIDTH-1:0] ALL_ZERO = {LANE_WIDTH{1'b0}};

  logic [W-1:0]            res_s;
  logic [LANES-1:0]        cout_s;
  logic [LANES-1:0]        ovf_s;
  logic [LANE_WIDTH-1:0]   a_s;
  logic [LANE_WIDTH-1:0]   b_s;
  logic [LANE_WIDTH-1:0]   r_s;
  logic [LANE_WIDTH:0]     sum_s;
  logic                    ovf_lane_s;

  logic [PIPELINE-1:0]               valid_q, valid_d;
  logic [PIPELINE-1:0][W-1:0]        res_q, res_d;
  logic [PIPELINE-1:0][LANES-1:0]    cout_q, cout_d;
  logic [PIPELINE-1:0][LANES-1:0]    ovf_q, ovf_d;
  logic                              rdy_s;
  logic                              in_ready_s;

  // Per-lane arithmetic; subtract is a + ~b + cin so cout is the not-borrow.
  always_comb begin
    res_s      = '0;
    cout_s     = '0;
    ovf_s      = '0;
    a_s        = '0;
    b_s        = '0;
    r_s        = '0;
    sum_s      = '0;
    ovf_lane_s = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      a_s = dataa[l*LANE_WIDTH +: LANE_WIDTH];
      if (add_sub) begin
        b_s = datab[l*LANE_WIDTH +: LANE_WIDTH];
      end else begin
        b_s = ~datab[l*LANE_WIDTH +: LANE_WIDTH];
      end
      sum_s = {1'b0, a_s} + {1'b0, b_s} + {{LANE_WIDTH{1'b0}}, cin[l]};
      r_s   = sum_s[LANE_WIDTH-1:0];
      if (SIGNED != 0) begin
        ovf_lane_s = (a_s[LANE_WIDTH-1] == b_s[LANE_WIDTH-1]) &&
                     (r_s[LANE_WIDTH-1] != a_s[LANE_WIDTH-1]);
      end else if (add_sub) begin
        ovf_lane_s = sum_s[LANE_WIDTH];
      end else begin
        ovf_lane_s = ~sum_s[LANE_WIDTH];
      end
      if ((SATURATE != 0) && ovf_lane_s) begin
        if (SIGNED != 0) begin
          r_s = a_s[LANE_WIDTH-1] ? MIN_NEG : MAX_POS;
        end else begin
          r_s = add_sub ? ALL_ONES : ALL_ZERO;
        end
      end else begin
        r_s = sum_s[LANE_WIDTH-1:0];
      end
      res_s[l*LANE_WIDTH +: LANE_WIDTH] = r_s;
      cout_s[l] = sum_s[LANE_WIDTH];
      ovf_s[l]  = ovf_lane_s;
    end
  end

  // Ready ripples back from the output; a stage loads when empty or draining.
  always_comb begin
    valid_d    = valid_q;
    res_d      = res_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    rdy_s      = out_ready;
    in_ready_s = 1'b0;
    for (int k = PIPELINE-1; k >= 1; k--) begin
      rdy_s = ~valid_q[k] | rdy_s;
      if (rdy_s) begin
        valid_d[k] = valid_q[k-1];
      end else begin
        valid_d[k] = valid_q[k];
      end
      if (rdy_s && valid_q[k-1]) begin
        res_d[k]  = res_q[k-1];
        cout_d[k] = cout_q[k-1];
        ovf_d[k]  = ovf_q[k-1];
      end else begin
        res_d[k]  = res_q[k];
        cout_d[k] = cout_q[k];
        ovf_d[k]  = ovf_q[k];
      end
    end
    rdy_s      = ~valid_q[0] | rdy_s;
    in_ready_s = rdy_s;
    if (rdy_s) begin
      valid_d[0] = in_valid;
    end else begin
      valid_d[0] = valid_q[0];
    end
    if (rdy_s && in_valid) begin
      res_d[0]  = res_s;
      cout_d[0] = cout_s;
      ovf_d[0]  = ovf_s;
    end else begin
      res_d[0]  = res_q[0];
      cout_d[0] = cout_q[0];
      ovf_d[0]  = ovf_q[0];
    end
  end

  // Stage registers; reset clears valids and payload so outputs read zero.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      valid_q <= '0;
      res_q   <= '0;
      cout_q  <= '0;
      ovf_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_q[PIPELINE-1];
  assign result    = res_q[PIPELINE-1];
  assign cout      = cout_q[PIPELINE-1];
  assign overflow  = ovf_q[PIPELINE-1];
endmodule

// File: tb/tb_lpm_add_sub_pipe.sv
// Scoreboard bench: three 4x8-bit configurations share one random stimulus stream;
// each has its own expected-beat queue fed on acceptance and drained by a monitor.
module tb_lpm_add_sub_pipe;
  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  c;
    logic [3:0]  o;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        aclr_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        add_sub = 1'b0;
  logic [31:0] dataa = 32'h0;
  logic [31:0] datab = 32'h0;
  logic [3:0]  cin = 4'h0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic per 8-bit lane.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] ci, input logic ad,
                                 input int sgn, input int sat);
    exp_t e;
    int ua, ub, ic, nb, full, r, sa, sb, tru;
    logic c, o;
    e = '0;
    for (int l = 0; l < 4; l++) begin
      ua = int'(a[l*8 +: 8]);
      ub = int'(b[l*8 +: 8]);
      ic = int'(ci[l]);
      nb = 1 - ic;
      if (ad) begin
        full = ua + ub + ic;
        c = (full >= 256);
        r = full % 256;
      end else begin
        c = (ua >= ub + nb);
        r = (ua - ub - nb + 256) % 256;
      end
      sa  = (ua >= 128) ? ua - 256 : ua;
      sb  = (ub >= 128) ? ub - 256 : ub;
      tru = ad ? sa + sb + ic : sa - sb - nb;
      if (sgn != 0) o = (tru > 127) || (tru < -128);
      else          o = ad ? c : !c;
      if ((sat != 0) && o) r = (sgn != 0) ? ((ua >= 128) ? 128 : 127) : (ad ? 255 : 0);
      e.r[l*8 +: 8] = r[7:0];
      e.c[l] = c;
      e.o[l] = o;
    end
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int PIPE = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    localparam int SGN  = (g == 2) ? 0 : 1;
    localparam int SAT  = (g == 0) ? 0 : 1;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [3:0]  cout, overflow;
    exp_t        q[$];
    exp_t        e_n;
    bit          presented = 1'b0;
    int          last_hold = -1;

    lpm_add_sub_pipe #(.LANE_WIDTH(8), .LANES(4), .PIPELINE(PIPE),
                       .SIGNED(SGN), .SATURATE(SAT)) u_dut (
      .clock(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready),
      .dataa(dataa), .datab(datab), .cin(cin), .add_sub(add_sub),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .cout(cout), .overflow(overflow));

    always @(negedge aclr_n) begin
      q.delete();
      presented = 1'b0;
    end

    always @(negedge clk) begin
      if (aclr_n) begin
        chk($sformatf("in_ready_c%0d", g), in_ready,
            (q.size() == PIPE && !out_ready) ? 0 : 1);
        if (out_valid) begin
          if (q.size() == 0) begin
            chk($sformatf("spurious_c%0d", g), out_valid, 0);
          end else begin
            chk($sformatf("payload_c%0d", g), {result, cout, overflow},
                {q[0].r, q[0].c, q[0].o});
            if (!presented) begin
              if (last_hold < q[0].acc) chk($sformatf("latency_c%0d", g), cyc - q[0].acc, PIPE);
              else chk($sformatf("latency_min_c%0d", g), (cyc - q[0].acc) >= PIPE, 1);
              presented = 1'b1;
            end
            if (out_ready) begin
              void'(q.pop_front());
              presented = 1'b0;
            end else begin
              last_hold = cyc;
            end
          end
        end
        if (in_valid && in_ready) begin
          e_n = model(dataa, datab, cin, add_sub, SGN, SAT);
          e_n.acc = cyc;
          q.push_back(e_n);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h7F7F_7F7F;
      1: return 32'h8080_8080;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_beat();
    dataa   = pick();
    datab   = pick();
    cin     = 4'($urandom);
    add_sub = 1'($urandom);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_vld0"}, cfg[0].out_valid, 0);
    chk({tag, "_vld1"}, cfg[1].out_valid, 0);
    chk({tag, "_vld2"}, cfg[2].out_valid, 0);
    chk({tag, "_pay0"}, {cfg[0].result, cfg[0].cout, cfg[0].overflow}, 0);
    chk({tag, "_pay1"}, {cfg[1].result, cfg[1].cout, cfg[1].overflow}, 0);
    chk({tag, "_pay2"}, {cfg[2].result, cfg[2].cout, cfg[2].overflow}, 0);
    chk({tag, "_rdy0"}, cfg[0].in_ready, 1);
    chk({tag, "_rdy1"}, cfg[1].in_ready, 1);
    chk({tag, "_rdy2"}, cfg[2].in_ready, 1);
  endtask

  // One beat on empty pipes; expectations are {result, cout, overflow} per config.
  task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ci, input logic ad,
                          input logic [39:0] e0, input logic [39:0] e1, input logic [39:0] e2);
    dataa = a; datab = b; cin = ci; add_sub = ad;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({nm, "_vld_p1"}, cfg[2].out_valid, 1);
    chk({nm, "_unsat"}, {cfg[2].result, cfg[2].cout, cfg[2].overflow}, e2);
    step();
    chk({nm, "_vld_p2"}, cfg[0].out_valid, 1);
    chk({nm, "_wrap"}, {cfg[0].result, cfg[0].cout, cfg[0].overflow}, e0);
    step();
    chk({nm, "_vld_p3"}, cfg[1].out_valid, 1);
    chk({nm, "_ssat"}, {cfg[1].result, cfg[1].cout, cfg[1].overflow}, e1);
  endtask

  initial begin
    repeat (3) step();
    rst_chk("reset");
    aclr_n = 1'b1;
    out_ready = 1'b1;
    step();

    directed("add_7f_01", 32'h0000_007F, 32'h0000_0001, 4'h0, 1'b1,
             {32'h0000_0080, 4'b0000, 4'b0001}, {32'h0000_007F, 4'b0000, 4'b0001},
             {32'h0000_0080, 4'b0000, 4'b0000});
    directed("sub_05_07", 32'h0000_0005, 32'h0000_0007, 4'hF, 1'b0,
             {32'h0000_00FE, 4'b1110, 4'b0000}, {32'h0000_00FE, 4'b1110, 4'b0000},
             {32'h0000_0000, 4'b1110, 4'b0001});
    directed("sub_05_07_b", 32'h0000_0005, 32'h0000_0007, 4'hE, 1'b0,
             {32'h0000_00FD, 4'b1110, 4'b0000}, {32'h0000_00FD, 4'b1110, 4'b0000},
             {32'h0000_0000, 4'b1110, 4'b0001});
    directed("sub_80_01", 32'h0000_0080, 32'h0000_0001, 4'hF, 1'b0,
             {32'h0000_007F, 4'b1111, 4'b0001}, {32'h0000_0080, 4'b1111, 4'b0001},
             {32'h0000_007F, 4'b1111, 4'b0000});
    directed("add_f0_20", 32'h0000_00F0, 32'h0000_0020, 4'h0, 1'b1,
             {32'h0000_0010, 4'b0001, 4'b0000}, {32'h0000_0010, 4'b0001, 4'b0000},
             {32'h0000_00FF, 4'b0001, 4'b0001});
    directed("sub_10_20", 32'h0000_0010, 32'h0000_0020, 4'hF, 1'b0,
             {32'h0000_00F0, 4'b1110, 4'b0000}, {32'h0000_00F0, 4'b1110, 4'b0000},
             {32'h0000_0000, 4'b1110, 4'b0001});
    directed("lanes", 32'hFF01_7F00, 32'h0101_0100, 4'h0, 1'b1,
             {32'h0002_8000, 4'b1000, 4'b0010}, {32'h0002_7F00, 4'b1000, 4'b0010},
             {32'hFF02_8000, 4'b1000, 4'b1000});

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rand_beat();
      step();
    end

    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_beat();
      step();
    end
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom);
      rand_beat();
      step();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("drain_c0", cfg[0].q.size(), 0);
    chk("drain_c1", cfg[1].q.size(), 0);
    chk("drain_c2", cfg[2].q.size(), 0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_beat();
      step();
    end
    in_valid = 1'b0;
    chk("inflight_c1", cfg[1].q.size(), 3);
    aclr_n = 1'b0;
    #1;
    rst_chk("midrst");
    step();
    step();
    aclr_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stale_c0", cfg[0].out_valid, 0);
      chk("stale_c1", cfg[1].out_valid, 0);
      chk("stale_c2", cfg[2].out_valid, 0);
    end
    directed("post_rst", 32'hFF01_7F00, 32'h0101_0100, 4'h0, 1'b1,
             {32'h0002_8000, 4'b1000, 4'b0010}, {32'h0002_7F00, 4'b1000, 4'b0010},
             {32'hFF02_8000, 4'b1000, 4'b1000});
    repeat (3) step();
    chk("final_c0", cfg[0].q.size(), 0);
    chk("final_c1", cfg[1].q.size(), 0);
    chk("final_c2", cfg[2].q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
